// File: rtl/flash_line_fill.sv
// Cache line refill engine between the I/D caches and the SPI flash controller.
// Fetches WORDS_PER_LINE single-word SPI reads per miss; dcache has priority.
//
// Ports:
//   CLK, resetn               clock, async active-low reset
//   icache_req/addr           icache line-miss request (level) and byte address
//   icache_line/fill_valid    assembled icache line, one-cycle valid pulse
//   dcache_req/addr           dcache line-miss request (level) and byte address
//   dcache_line/fill_valid    assembled dcache line, one-cycle valid pulse
//   spi_req/addr              word-read request (level) and word byte address
//   spi_data/data_ready       returned word and its one-cycle strobe
//   busy                      engine not idle
module flash_line_fill #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 20
) (
  input  logic                         CLK,
  input  logic                         resetn,
  input  logic                         icache_req,
  input  logic [ADDR_W-1:0]            icache_addr,
  output logic [32*WORDS_PER_LINE-1:0] icache_line,
  output logic                         icache_fill_valid,
  input  logic                         dcache_req,
  input  logic [ADDR_W-1:0]            dcache_addr,
  output logic [32*WORDS_PER_LINE-1:0] dcache_line,
  output logic                         dcache_fill_valid,
  output logic                         spi_req,
  output logic [ADDR_W-1:0]            spi_addr,
  input  logic [31:0]                  spi_data,
  input  logic                         spi_data_ready,
  output logic                         busy
);

  localparam int LW    = 32 * WORDS_PER_LINE;
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~ADDR_W'(WORDS_PER_LINE * 4 - 1);

  logic [1:0]        r_state;
  logic [1:0]        r_owner;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_base;
  logic [LW-1:0]     r_iline;
  logic [LW-1:0]     r_dline;

  logic              w_owner_req;
  logic              w_abort;
  logic              w_take;
  logic              w_last;
  logic [ADDR_W-1:0] w_ibase;
  logic [ADDR_W-1:0] w_dbase;
  logic [ADDR_W-1:0] w_off;

  // Line base: requester address with the in-line byte offset cleared.
  assign w_ibase = icache_addr & LINE_MASK;
  assign w_dbase = dcache_addr & LINE_MASK;

  assign w_off = ADDR_W'({r_idx, 2'b00});

  always_comb begin
    w_owner_req = 1'b0;
    unique case (1'b1)
      (r_owner == OWN_D): w_owner_req = dcache_req;
      (r_owner == OWN_I): w_owner_req = icache_req;
      default:            w_owner_req = 1'b0;
    endcase
  end

  // The owner may abandon its miss while a word is outstanding.
  assign w_abort = ((r_state == S_REQ) || (r_state == S_GAP))
                 && !w_owner_req;

  // A returned word only counts when no abort wins the same cycle.
  assign w_take = (r_state == S_REQ) && spi_data_ready && !w_abort;

  assign w_last = (r_idx == IDX_W'(WORDS_PER_LINE - 1));

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_owner <= OWN_NONE;
      r_idx   <= '0;
      r_base  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (dcache_req) begin
            r_state <= S_REQ;
            r_owner <= OWN_D;
            r_base  <= w_dbase;
            r_idx   <= '0;
          end else if (icache_req) begin
            r_state <= S_REQ;
            r_owner <= OWN_I;
            r_base  <= w_ibase;
            r_idx   <= '0;
          end
        end
        S_REQ: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
            r_idx   <= '0;
          end else if (spi_data_ready) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
            r_idx   <= '0;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
          r_idx   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_owner <= OWN_NONE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_iline <= '0;
      r_dline <= '0;
    end else begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        if (w_take && (r_idx == IDX_W'(w))) begin
          if (r_owner == OWN_D) r_dline[w*32 +: 32] <= spi_data;
          if (r_owner == OWN_I) r_iline[w*32 +: 32] <= spi_data;
        end
      end
    end
  end

  assign spi_req  = (r_state == S_REQ);
  assign spi_addr = r_base + w_off;
  assign busy     = (r_state != S_IDLE);

  assign icache_fill_valid = (r_state == S_DONE) && (r_owner == OWN_I);
  assign dcache_fill_valid = (r_state == S_DONE) && (r_owner == OWN_D);

  assign icache_line = r_iline;
  assign dcache_line = r_dline;

endmodule

// File: tb/tb_flash_line_fill.sv
// Self-checking bench for flash_line_fill (4- and 8-word lines).
// SPI controller modelled with random per-word latency.
module tb_flash_line_fill;

  logic         CLK = 1'b0;
  logic         resetn;

  logic         ireq, dreq;
  logic [19:0]  iaddr, daddr;
  logic [127:0] iline4, dline4;
  logic         ifill4, dfill4;
  logic         sreq4, srdy4, busy4;
  logic [19:0]  saddr4;
  logic [31:0]  sdata4;

  logic         ireq8, dreq8;
  logic [19:0]  iaddr8, daddr8;
  logic [255:0] iline8, dline8;
  logic         ifill8, dfill8;
  logic         sreq8, srdy8, busy8;
  logic [19:0]  saddr8;
  logic [31:0]  sdata8;

  int nvec = 0;
  int nerr = 0;

  logic [19:0] log4[$];
  logic [19:0] log8[$];
  int icnt = 0, dcnt = 0, dcnt8 = 0;
  int nrise = 0, bad_gap = 0, gaplen = 0;
  logic prev_req = 1'b0;

  always #5 CLK = ~CLK;

  flash_line_fill #(.WORDS_PER_LINE(4), .ADDR_W(20)) dut4 (
    .CLK(CLK), .resetn(resetn),
    .icache_req(ireq), .icache_addr(iaddr),
    .icache_line(iline4), .icache_fill_valid(ifill4),
    .dcache_req(dreq), .dcache_addr(daddr),
    .dcache_line(dline4), .dcache_fill_valid(dfill4),
    .spi_req(sreq4), .spi_addr(saddr4),
    .spi_data(sdata4), .spi_data_ready(srdy4),
    .busy(busy4)
  );

  flash_line_fill #(.WORDS_PER_LINE(8), .ADDR_W(20)) dut8 (
    .CLK(CLK), .resetn(resetn),
    .icache_req(ireq8), .icache_addr(iaddr8),
    .icache_line(iline8), .icache_fill_valid(ifill8),
    .dcache_req(dreq8), .dcache_addr(daddr8),
    .dcache_line(dline8), .dcache_fill_valid(dfill8),
    .spi_req(sreq8), .spi_addr(saddr8),
    .spi_data(sdata8), .spi_data_ready(srdy8),
    .busy(busy8)
  );

  // SPI controller model: latch address when req seen, answer after 1..3 cycles.
  initial begin
    logic        mb;
    int          mc;
    logic [19:0] ma;
    mb = 1'b0; mc = 0; ma = '0;
    srdy4 = 1'b0; sdata4 = '0;
    forever begin
      @(negedge CLK);
      srdy4 = 1'b0;
      if (!resetn || !sreq4) mb = 1'b0;
      else if (!mb) begin
        mb = 1'b1; ma = saddr4; mc = $urandom_range(1, 3);
      end else if (mc > 1) mc--;
      else begin
        srdy4 = 1'b1; sdata4 = 32'hA000_0000 + 32'(ma);
        log4.push_back(ma); mb = 1'b0;
      end
    end
  end

  initial begin
    logic        mb;
    int          mc;
    logic [19:0] ma;
    mb = 1'b0; mc = 0; ma = '0;
    srdy8 = 1'b0; sdata8 = '0;
    forever begin
      @(negedge CLK);
      srdy8 = 1'b0;
      if (!resetn || !sreq8) mb = 1'b0;
      else if (!mb) begin
        mb = 1'b1; ma = saddr8; mc = $urandom_range(1, 3);
      end else if (mc > 1) mc--;
      else begin
        srdy8 = 1'b1; sdata8 = 32'hA000_0000 + 32'(ma);
        log8.push_back(ma); mb = 1'b0;
      end
    end
  end

  // Pulse counters and request-gap monitor.
  initial forever begin
    @(negedge CLK);
    if (ifill4) icnt++;
    if (dfill4) dcnt++;
    if (dfill8) dcnt8++;
    if (sreq4 && !prev_req) nrise++;
    prev_req = sreq4;
    if (!busy4) gaplen = 0;
    else if (!sreq4) gaplen++;
    else begin
      if (gaplen > 1) bad_gap++;
      gaplen = 0;
    end
  end

  task automatic chk(input string nm, input logic [255:0] a,
                     input logic [255:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // Expected line: word k = 0xA0000000 + base + 4k.
  function automatic logic [255:0] mk_line(input logic [19:0] b,
                                           input int n);
    logic [255:0] l;
    l = '0;
    for (int k = 0; k < n; k++)
      l[k*32 +: 32] = 32'hA000_0000 + 32'(b) + 32'(4 * k);
    return l;
  endfunction

  function automatic int seq4_bad(input logic [19:0] b);
    int bad;
    bad = 0;
    if (log4.size() < 4) return 99;
    for (int k = 0; k < 4; k++)
      if (log4[k] !== b + 20'(4 * k)) bad++;
    return bad;
  endfunction

  task automatic wait_sig(input string nm, input int which);
    int t;
    logic s;
    t = 0;
    s = 1'b0;
    do begin
      @(negedge CLK);
      t++;
      unique case (which)
        0: s = ifill4;
        1: s = dfill4;
        2: s = dfill8;
        default: s = 1'b0;
      endcase
    end while (!s && t < 600);
    chki({nm, "_timeout"}, int'(t >= 600), 0);
  endtask

  task automatic do_fill(input bit is_d, input logic [19:0] a,
                         input logic [19:0] b);
    int ic0, dc0;
    @(negedge CLK);
    log4.delete();
    nrise = 0; bad_gap = 0; ic0 = icnt; dc0 = dcnt;
    if (is_d) begin dreq = 1'b1; daddr = a; end
    else begin ireq = 1'b1; iaddr = a; end
    wait_sig("fill", is_d ? 1 : 0);
    chk("line", is_d ? dline4 : iline4, mk_line(b, 4));
    dreq = 1'b0; ireq = 1'b0;
    chki("spi_addr_seq", seq4_bad(b), 0);
    chki("word_count", log4.size(), 4);
    repeat (3) @(negedge CLK);
    chki("pulse_own", is_d ? dcnt - dc0 : icnt - ic0, 1);
    chki("pulse_other", is_d ? icnt - ic0 : dcnt - dc0, 0);
    chki("gap_long", bad_gap, 0);
    chki("req_rises", nrise, 4);
    chk("line_hold", is_d ? dline4 : iline4, mk_line(b, 4));
    chk("idle_busy", busy4, 0);
  endtask

  typedef struct {
    bit          is_d;
    logic [19:0] addr;
    logic [19:0] base;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   dc0, ic0;
    tbl[0] = '{1'b1, 20'h01234, 20'h01230};
    tbl[1] = '{1'b0, 20'hFFFFF, 20'hFFFF0};
    tbl[2] = '{1'b1, 20'h0000F, 20'h00000};
    tbl[3] = '{1'b0, 20'h12345, 20'h12340};

    resetn = 1'b0;
    ireq = 0; dreq = 0; iaddr = '0; daddr = '0;
    ireq8 = 0; dreq8 = 0; iaddr8 = '0; daddr8 = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", busy4, 0);
    chk("rst_spi_req", sreq4, 0);
    chk("rst_spi_addr", saddr4, 0);
    chk("rst_fill", {ifill4, dfill4}, 0);
    chk("rst_lines", {iline4, dline4}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_rst_idle", {busy4, sreq4}, 0);

    for (int i = 0; i < 4; i++)
      do_fill(tbl[i].is_d, tbl[i].addr, tbl[i].base);

    // Simultaneous requests: dcache first, icache granted right after.
    @(negedge CLK);
    log4.delete();
    ic0 = icnt; dc0 = dcnt;
    dreq = 1'b1; daddr = 20'h00200;
    ireq = 1'b1; iaddr = 20'h00100;
    wait_sig("both_d", 1);
    chk("both_dline", dline4, mk_line(20'h00200, 4));
    chki("both_dseq", seq4_bad(20'h00200), 0);
    chki("both_no_ifill", icnt - ic0, 0);
    dreq = 1'b0;
    @(negedge CLK);
    chk("both_idle_gap", {busy4, sreq4}, 0);
    @(negedge CLK);
    chk("both_i_start", {sreq4, saddr4}, {1'b1, 20'h00100});
    log4.delete();
    wait_sig("both_i", 0);
    chk("both_iline", iline4, mk_line(20'h00100, 4));
    ireq = 1'b0;
    chki("both_iseq", seq4_bad(20'h00100), 0);
    chk("both_dhold", dline4, mk_line(20'h00200, 4));

    // Abort while requesting word 2.
    @(negedge CLK);
    dc0 = dcnt;
    dreq = 1'b1; daddr = 20'h00300;
    begin
      int t;
      t = 0;
      while (!(sreq4 && saddr4 == 20'h00308) && t < 200) begin
        @(negedge CLK); t++;
      end
      chki("abort_reach", int'(t >= 200), 0);
    end
    dreq = 1'b0;
    @(negedge CLK);
    chk("abort_drop", {sreq4, busy4}, 0);
    repeat (6) @(negedge CLK);
    chki("abort_no_fill", dcnt - dc0, 0);
    do_fill(1'b0, 20'h00444, 20'h00440);

    // Async reset in the GAP after word 1.
    @(negedge CLK);
    dreq = 1'b1; daddr = 20'h00505;
    begin
      int t;
      t = 0;
      while (!(busy4 && !sreq4 && saddr4 == 20'h00508) && t < 200) begin
        @(negedge CLK); t++;
      end
      chki("gap_reach", int'(t >= 200), 0);
    end
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_out", {busy4, sreq4, saddr4, ifill4, dfill4}, 0);
    chk("mid_rst_lines", {iline4, dline4}, 0);
    dreq = 1'b0;
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    do_fill(1'b1, 20'h0050A, 20'h00500);

    // Randomized misses against the address-arithmetic model.
    for (int i = 0; i < 8; i++) begin
      logic [19:0] a;
      bit          d;
      a = 20'($urandom);
      d = 1'($urandom_range(0, 1));
      do_fill(d, a, a - (a % 20'd16));
    end

    // 8-word line instance.
    @(negedge CLK);
    log8.delete();
    dc0 = dcnt8;
    dreq8 = 1'b1; daddr8 = 20'h0003F;
    wait_sig("w8", 2);
    chk("w8_line", dline8, mk_line(20'h00020, 8));
    chki("w8_words", log8.size(), 8);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 8; k++)
        if (k >= log8.size() || log8[k] !== 20'h00020 + 20'(4 * k)) bad++;
      chki("w8_seq", bad, 0);
    end
    dreq8 = 1'b0;
    repeat (3) @(negedge CLK);
    chki("w8_pulse", dcnt8 - dc0, 1);
    chk("w8_idle", {busy8, ifill8}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/flash_line_fill.md
Name: flash_line_fill

Overview:
- Sits between the instruction/data caches and the SPI flash controller.
- On a cache miss it fetches a whole cache line from flash as a sequence of single-word SPI reads, assembles the words into a line buffer, and returns the line to the requesting cache with a one-cycle valid pulse.
- Arbitrates between icache and dcache misses; dcache has fixed priority.
- Presents a single request/address pair to the SPI controller.

Parameters:
- WORDS_PER_LINE, 4, 32-bit words per cache line; power of two, 2..8.
- ADDR_W, 20, byte-address width of CPU-side flash addresses.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous active-low reset.
- icache_req  in  1  icache line-miss request, level; held until icache_fill_valid or abandoned.
- icache_addr  in  ADDR_W  icache miss byte address; any byte within the line.
- icache_line  out  32*WORDS_PER_LINE  assembled line; word 0 in [31:0].
- icache_fill_valid  out  1  one-cycle pulse: icache_line is valid.
- dcache_req  in  1  dcache line-miss request, level.
- dcache_addr  in  ADDR_W  dcache miss byte address.
- dcache_line  out  32*WORDS_PER_LINE  assembled line; word 0 in [31:0].
- dcache_fill_valid  out  1  one-cycle pulse: dcache_line is valid.
- spi_req  out  1  word-read request to the SPI controller, level.
- spi_addr  out  ADDR_W  CPU-side word byte address; the controller applies the flash offset.
- spi_data  in  32  word returned by the SPI controller, already endian-corrected.
- spi_data_ready  in  1  one-cycle pulse: spi_data is valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE; idx=0; owner=none.
  - spi_req=0, spi_addr=0, both fill_valid=0, busy=0.
  - Line buffers cleared to 0.
  - Reset mid-fill abandons the fill; no fill_valid is emitted.
- Address arithmetic:
  - base = requester addr with the low log2(WORDS_PER_LINE*4) bits cleared.
  - spi_addr = base + 4*idx.
  - Base is aligned, so no carry ever leaves the line; e.g. base 0xFFFF0 yields 0xFFFF0..0xFFFFC and never wraps.
  - Addresses are passed through unchecked; range checking is the caller's job.
- States:
  - IDLE:
    - If dcache_req: latch base from dcache_addr, owner=D, idx=0, go to REQ.
    - Else if icache_req: same, with owner=I.
    - When both are asserted in the same cycle, dcache wins; the icache request stays pending and is served afterwards.
  - REQ:
    - spi_req=1 and spi_addr is stable.
    - On spi_data_ready: write spi_data into word[idx] of the owner's line buffer.
    - If idx==WORDS_PER_LINE-1, go to DONE; else idx+1 and go to GAP.
  - GAP:
    - spi_req=0 for exactly one cycle, so the controller returns to not-busy and re-latches the address.
    - Then go to REQ.
  - DONE:
    - Owner's fill_valid=1 for exactly this cycle; spi_req=0.
    - Next state is IDLE.
    - The requester must drop its req in the cycle after fill_valid, so IDLE does not re-grant it.
- Abort:
  - In REQ or GAP, if the owner's req is sampled 0, go to IDLE at the next edge.
  - spi_req goes low, the in-flight word is discarded, and no fill_valid is emitted.
  - The partially written line buffer keeps its contents; it is undefined to consumers.
- Non-owner requests are ignored until IDLE; there is no preemption, even by dcache.
- spi_data_ready outside REQ is ignored.
- Each line output holds its value from its last DONE until the next write to that buffer.
- Latency from grant to fill_valid is the sum of the per-word SPI latencies + (WORDS_PER_LINE-1) GAP cycles + 1 DONE cycle + 1 grant cycle.

Test Plan:
- Single dcache miss, dcache_addr=0x01234, SPI model returns 0xA0000000+addr:
  - spi_addr sequence is 0x01230, 0x01234, 0x01238, 0x0123C.
  - spi_req is low exactly 1 cycle between words.
  - dcache_line = {0xA000123C, 0xA0001238, 0xA0001234, 0xA0001230}.
  - One dcache_fill_valid pulse; icache_fill_valid stays 0.
- icache_req and dcache_req rise in the same cycle (addrs 0x00100, 0x00200):
  - dcache is filled first from 0x00200.
  - icache fill from 0x00100 starts in the cycle after dcache DONE->IDLE.
  - Both lines are correct.
- End-of-range line, icache_addr=0xFFFFF:
  - Addresses are 0xFFFF0..0xFFFFC with no wrap to 0x00000.
  - Line is correct.
- Abort: dcache_req drops while in REQ for word 2:
  - spi_req falls the next cycle and busy returns to 0.
  - dcache_fill_valid never asserts.
  - A subsequent icache miss completes normally.
- Async reset asserted mid-fill (in GAP after word 1):
  - All outputs are immediately 0 and the state is IDLE.
  - After release, a fresh dcache miss fills correctly from word 0.
- Parameter sweep WORDS_PER_LINE=8, addr 0x0003F:
  - base is 0x00020, with 8 words 0x00020..0x0003C.
  - Line width is 256 bits; fill_valid occurs after the 8th spi_data_ready.
